// File: rtl/dmem_bus_arbiter_pkg.sv
// Shared definitions for the data-memory bus arbiter: owner and FSM state
// encodings plus the default IO-select bit and lock hold limit.
package dmem_bus_arbiter_pkg;

   localparam int IO_BIT_DEFAULT   = 7;
   localparam int MAX_HOLD_DEFAULT = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_M0   = 2'b01,
      OWN_M1   = 2'b10
   } owner_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } state_t;

endpackage

// File: rtl/dmem_bus_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester wins, and on a
// tie the master that was not served last wins.
module rr_pick2
   import dmem_bus_arbiter_pkg::*;
(
   input  logic       req0,
   input  logic       req1,
   input  logic [1:0] last,
   output logic [1:0] grant
);

   always_comb begin
      grant = OWN_NONE;
      if (req0 && req1) begin
         grant = (last == OWN_M0) ? OWN_M1 : OWN_M0;
      end else if (req0) begin
         grant = OWN_M0;
      end else if (req1) begin
         grant = OWN_M1;
      end
   end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Two-master arbiter for the shared data RAM / IO bus: round-robin grant,
// optional bounded locking, IO/RAM write-strobe decode and read-data return.
module dmem_bus_arbiter
   import dmem_bus_arbiter_pkg::*;
#(
   parameter int IO_BIT   = IO_BIT_DEFAULT,
   parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic        m0_lock,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_ack,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic        m1_lock,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_ack,
   output logic [31:0] m1_rdata,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic        bus_mem_we,
   output logic        bus_io_we,
   input  logic [31:0] mem_rdata,
   input  logic [31:0] io_rdata,
   output logic [1:0]  owner
);

   localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   owner_t            last_q, last_d;
   logic [HOLD_W-1:0] hold_q, hold_d;

   logic [1:0]  pick_last;
   logic [1:0]  grant;
   logic        sel_m1;
   logic        sel_req;
   logic        sel_we;
   logic        sel_lock;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [31:0] sel_rdata;

   // Arbitration out of RESP treats the master just served as `last`, so the
   // register update and the pick in that cycle agree.
   assign pick_last = (state_q == RESP) ? owner_q : last_q;

   rr_pick2 u_pick (
      .req0  (m0_req),
      .req1  (m1_req),
      .last  (pick_last),
      .grant (grant)
   );

   assign sel_m1    = (owner_q == OWN_M1);
   assign sel_req   = sel_m1 ? m1_req   : m0_req;
   assign sel_we    = sel_m1 ? m1_we    : m0_we;
   assign sel_lock  = sel_m1 ? m1_lock  : m0_lock;
   assign sel_addr  = sel_m1 ? m1_addr  : m0_addr;
   assign sel_wdata = sel_m1 ? m1_wdata : m0_wdata;
   assign sel_rdata = sel_addr[IO_BIT] ? io_rdata : mem_rdata;

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned; a missing default would infer a latch.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            if (grant != OWN_NONE) begin
               state_d = ACCESS;
               owner_d = owner_t'(grant);
            end
         end
         ACCESS: state_d = RESP;
         RESP: begin
            last_d = owner_q;
            if (sel_lock && sel_req && (hold_q < HOLD_LAST)) begin
               state_d = ACCESS;
               hold_d  = hold_q + HOLD_W'(1);
            end else begin
               hold_d = '0;
               if (grant != OWN_NONE) begin
                  state_d = ACCESS;
                  owner_d = owner_t'(grant);
               end else begin
                  state_d = IDLE;
                  owner_d = OWN_NONE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            owner_d = OWN_NONE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= OWN_NONE;
         last_q  <= OWN_M1;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      m0_ack     = 1'b0;
      m0_rdata   = '0;
      m1_ack     = 1'b0;
      m1_rdata   = '0;
      bus_addr   = '0;
      bus_wdata  = '0;
      bus_mem_we = 1'b0;
      bus_io_we  = 1'b0;
      owner      = owner_q;
      case (state_q)
         ACCESS: begin
            bus_addr  = sel_addr;
            bus_wdata = sel_wdata;
            if (sel_we) begin
               bus_mem_we = ~sel_addr[IO_BIT];
               bus_io_we  = sel_addr[IO_BIT];
            end
         end
         RESP: begin
            bus_addr  = sel_addr;
            bus_wdata = sel_wdata;
            if (sel_m1) begin
               m1_ack   = 1'b1;
               m1_rdata = sel_rdata;
            end else begin
               m0_ack   = 1'b1;
               m0_rdata = sel_rdata;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Self-checking bench for dmem_bus_arbiter: vector table, hand-written
// multi-cycle sequences and a randomized run against a transaction-level model.
module tb_dmem_bus_arbiter;

   localparam int IO_BIT   = 7;
   localparam int MAX_HOLD = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_ack, m1_ack;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] bus_addr, bus_wdata;
   logic        bus_mem_we, bus_io_we;
   logic [31:0] mem_rdata, io_rdata;
   logic [1:0]  owner;

   dmem_bus_arbiter #(.IO_BIT(IO_BIT), .MAX_HOLD(MAX_HOLD)) dut (
      .clock(clock), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_mem_we(bus_mem_we),
      .bus_io_we(bus_io_we), .mem_rdata(mem_rdata), .io_rdata(io_rdata),
      .owner(owner)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: which master is in flight and in which half of its
   // two-cycle transaction, who was served last, and the lock streak length.
   int mdl_phase  = 0;  // 0 = bus free, 1 = address half, 2 = response half
   int mdl_cur    = 0;
   int mdl_prev   = 1;
   int mdl_streak = 0;

   function automatic int pick(input logic r0, input logic r1, input int prev);
      if (r0 && r1) return (prev == 0) ? 1 : 0;
      if (r0) return 0;
      if (r1) return 1;
      return -1;
   endfunction

   task automatic model_step();
      int w;
      logic cur_lock, cur_req;
      cur_lock = (mdl_cur == 1) ? m1_lock : m0_lock;
      cur_req  = (mdl_cur == 1) ? m1_req  : m0_req;
      if (reset) begin
         mdl_phase = 0; mdl_prev = 1; mdl_streak = 0;
      end else if (mdl_phase == 0) begin
         w = pick(m0_req, m1_req, mdl_prev);
         if (w >= 0) begin mdl_cur = w; mdl_phase = 1; end
      end else if (mdl_phase == 1) begin
         mdl_phase = 2;
      end else begin
         mdl_prev = mdl_cur;
         if (cur_lock && cur_req && mdl_streak < MAX_HOLD - 1) begin
            mdl_streak++;
            mdl_phase = 1;
         end else begin
            mdl_streak = 0;
            w = pick(m0_req, m1_req, mdl_prev);
            if (w >= 0) begin mdl_cur = w; mdl_phase = 1; end
            else mdl_phase = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      @(negedge clock);
   endtask

   task automatic clear_inputs();
      m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
      mem_rdata = 0; io_rdata = 0;
   endtask

   task automatic do_reset();
      reset = 1; clear_inputs();
      tick();
      reset = 0;
   endtask

   task automatic check_model(input string tag);
      logic [31:0] ca, cw, cr;
      logic        cwe;
      logic [1:0]  e_own;
      bit          act_ph, rsp_ph;
      ca  = (mdl_cur == 1) ? m1_addr  : m0_addr;
      cw  = (mdl_cur == 1) ? m1_wdata : m0_wdata;
      cwe = (mdl_cur == 1) ? m1_we    : m0_we;
      cr  = ca[IO_BIT] ? io_rdata : mem_rdata;
      act_ph = (mdl_phase == 1);
      rsp_ph = (mdl_phase == 2);
      e_own  = (mdl_phase == 0) ? 2'b00 : ((mdl_cur == 1) ? 2'b10 : 2'b01);
      check({tag, " owner"}, owner, e_own);
      check({tag, " bus_addr"}, bus_addr, (mdl_phase != 0) ? ca : 32'h0);
      if (!rsp_ph) check({tag, " bus_wdata"}, bus_wdata, act_ph ? cw : 32'h0);
      check({tag, " strobes"}, {bus_mem_we, bus_io_we},
            {act_ph && cwe && !ca[IO_BIT], act_ph && cwe && ca[IO_BIT]});
      check({tag, " acks"}, {m0_ack, m1_ack},
            {rsp_ph && mdl_cur == 0, rsp_ph && mdl_cur == 1});
      check({tag, " m0_rdata"}, m0_rdata, (rsp_ph && mdl_cur == 0) ? cr : 32'h0);
      check({tag, " m1_rdata"}, m1_rdata, (rsp_ph && mdl_cur == 1) ? cr : 32'h0);
      check({tag, " one_strobe"}, bus_mem_we & bus_io_we, 0);
      check({tag, " one_ack"}, m0_ack & m1_ack, 0);
   endtask

   typedef struct {
      bit          m1;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrd;
      logic [31:0] ird;
      bit          e_mwe;
      bit          e_iwe;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int m0_acks, m1_acks, c, first_m1, idle_cycles;
      bit m1_seen;

      vecs[0] = '{0, 0, 32'h0000_0010, 32'h0,         32'h1234_5678, 32'hDEAD_BEEF, 0, 0, 32'h1234_5678};
      vecs[1] = '{1, 1, 32'h0000_0080, 32'h0000_00A5, 32'h1111_1111, 32'h2222_2222, 0, 1, 32'h2222_2222};
      vecs[2] = '{0, 1, 32'h0000_0044, 32'hCAFE_F00D, 32'h3333_3333, 32'h4444_4444, 1, 0, 32'h3333_3333};
      vecs[3] = '{1, 0, 32'h0001_0080, 32'h0,         32'h5555_5555, 32'h6666_6666, 0, 0, 32'h6666_6666};
      vecs[4] = '{0, 0, 32'hFFFF_FF7F, 32'h0,         32'h7777_7777, 32'h8888_8888, 0, 0, 32'h7777_7777};
      vecs[5] = '{1, 1, 32'hFFFF_FFFF, 32'h0BAD_CAFE, 32'h9999_9999, 32'hAAAA_AAAA, 0, 1, 32'hAAAA_AAAA};

      // Reset state
      reset = 1; clear_inputs();
      @(negedge clock);
      tick();
      #1;
      check("reset owner", owner, 2'b00);
      check("reset acks", {m0_ack, m1_ack}, 2'b00);
      check("reset strobes", {bus_mem_we, bus_io_we}, 2'b00);
      check("reset bus", {bus_addr, bus_wdata}, 64'h0);
      reset = 0;

      // Vector table: one isolated transaction per entry
      foreach (vecs[i]) begin
         vec_t v;
         v = vecs[i];
         mem_rdata = v.mrd; io_rdata = v.ird;
         if (v.m1) begin
            m1_req = 1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
         end else begin
            m0_req = 1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
         end
         tick();
         m0_req = 0; m1_req = 0;   // dropped during ACCESS; must still complete
         #1;
         check($sformatf("vec%0d access owner", i), owner, v.m1 ? 2'b10 : 2'b01);
         check($sformatf("vec%0d access addr", i), bus_addr, v.addr);
         check($sformatf("vec%0d access wdata", i), bus_wdata, v.wdata);
         check($sformatf("vec%0d access strobes", i), {bus_mem_we, bus_io_we}, {v.e_mwe, v.e_iwe});
         check($sformatf("vec%0d access acks", i), {m0_ack, m1_ack}, 2'b00);
         tick(); #1;
         check($sformatf("vec%0d resp acks", i), {m0_ack, m1_ack}, v.m1 ? 2'b01 : 2'b10);
         check($sformatf("vec%0d resp rdata", i), v.m1 ? m1_rdata : m0_rdata, v.e_rdata);
         check($sformatf("vec%0d resp other rdata", i), v.m1 ? m0_rdata : m1_rdata, 32'h0);
         check($sformatf("vec%0d resp strobes", i), {bus_mem_we, bus_io_we}, 2'b00);
         check($sformatf("vec%0d resp addr", i), bus_addr, v.addr);
         tick(); #1;
         check($sformatf("vec%0d idle owner", i), owner, 2'b00);
         check($sformatf("vec%0d idle acks", i), {m0_ack, m1_ack}, 2'b00);
      end

      // Simultaneous requests after reset: M0 first, M1 with no bubble
      do_reset();
      m0_req = 1; m0_addr = 32'h100; m1_req = 1; m1_addr = 32'h204;
      mem_rdata = 32'h0000_0101;
      tick(); #1; check("tie c1 owner", owner, 2'b01);
      tick(); #1; check("tie c2 m0_ack", {m0_ack, m1_ack}, 2'b10);
      m0_req = 0;
      tick(); #1; check("tie c3 owner", owner, 2'b10);
      tick(); #1; check("tie c4 m1_ack", {m0_ack, m1_ack}, 2'b01);
      check("tie c4 m1_rdata", m1_rdata, 32'h0000_0101);
      m1_req = 0;
      tick(); #1; check("tie c5 owner", owner, 2'b00);

      // Lock with contention: exactly MAX_HOLD M0 transactions, then M1
      do_reset();
      m0_req = 1; m0_lock = 1; m0_addr = 32'h20;
      m1_req = 1; m1_addr = 32'h84;
      m0_acks = 0; first_m1 = -1;
      for (c = 1; c <= 40 && first_m1 < 0; c++) begin
         tick(); #1;
         if (m0_ack) m0_acks++;
         if (m1_ack) begin first_m1 = c; m1_req = 0; end
      end
      check("lock m1 ack cycle", first_m1, 10);
      check("lock m0 acks before handover", m0_acks, MAX_HOLD);

      // Lock without contention: M0 keeps the bus with no idle cycle
      m0_acks = 0; m1_acks = 0; idle_cycles = 0;
      for (int k = 0; k < 20; k++) begin
         tick(); #1;
         if (m0_ack) m0_acks++;
         if (m1_ack) m1_acks++;
         if (owner != 2'b01) idle_cycles++;
      end
      check("solo lock m0 acks", m0_acks, 10);
      check("solo lock m1 acks", m1_acks, 0);
      check("solo lock non-M0 cycles", idle_cycles, 0);
      m0_req = 0; m0_lock = 0;
      tick();

      // Reset during ACCESS of an M1 read
      do_reset();
      m1_req = 1; m1_addr = 32'h30; mem_rdata = 32'h0000_3030;
      tick(); #1; check("rst-mid access owner", owner, 2'b10);
      reset = 1;
      tick(); #1;
      check("rst-mid owner", owner, 2'b00);
      check("rst-mid acks", {m0_ack, m1_ack}, 2'b00);
      check("rst-mid strobes", {bus_mem_we, bus_io_we}, 2'b00);
      reset = 0; m1_req = 0;
      m0_req = 1; m0_we = 0; m0_addr = 32'h40; mem_rdata = 32'h0000_4040;
      tick(); #1; check("rst-mid m0 owner", owner, 2'b01);
      m0_req = 0;
      tick(); #1;
      check("rst-mid m0 ack", m0_ack, 1'b1);
      check("rst-mid m0 rdata", m0_rdata, 32'h0000_4040);

      // Withdrawn M1 request while M0 owns the bus
      do_reset();
      m1_seen = 0;
      m0_req = 1; m0_addr = 32'h50;
      tick(); m0_req = 0; m1_req = 1; #1;
      if (m1_ack) m1_seen = 1;
      tick(); m1_req = 0; #1;
      check("withdraw m0 ack", m0_ack, 1'b1);
      if (m1_ack) m1_seen = 1;
      for (int k = 0; k < 4; k++) begin
         tick(); #1;
         if (m1_ack) m1_seen = 1;
         check($sformatf("withdraw idle owner %0d", k), owner, 2'b00);
      end
      check("withdraw m1 never acked", m1_seen, 1'b0);

      // Randomized run against the reference model
      do_reset();
      for (int k = 0; k < 800; k++) begin
         reset = ($urandom_range(0, 59) == 0);
         m0_req  = ($urandom_range(0, 2) != 0);
         m1_req  = ($urandom_range(0, 2) != 0);
         m0_lock = $urandom_range(0, 1);
         m1_lock = $urandom_range(0, 1);
         if (!(mdl_phase != 0 && mdl_cur == 0)) begin
            m0_we = $urandom_range(0, 1); m0_addr = $urandom; m0_wdata = $urandom;
         end
         if (!(mdl_phase != 0 && mdl_cur == 1)) begin
            m1_we = $urandom_range(0, 1); m1_addr = $urandom; m1_wdata = $urandom;
         end
         mem_rdata = $urandom; io_rdata = $urandom;
         #1;
         check_model("rand");
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
